// File: rtl/gamepad_pmod_rx.sv
// Gamepad PMOD receiver: synchronises latch/clk/data, deserialises a 24-bit
// two-controller frame and publishes registered button words per good frame.
module gamepad_pmod_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pmod_latch,
    input  logic        pmod_clk,
    input  logic        pmod_data,
    output logic [11:0] pad1_buttons,
    output logic [11:0] pad2_buttons,
    output logic        pad1_present,
    output logic        pad2_present,
    output logic        frame_valid,
    output logic        frame_err
);
    localparam logic [4:0] FRAME_BITS = 5'd24;
    localparam logic [4:0] BITCNT_OVF = 5'd25;

    logic [SYNC_STAGES-1:0] latch_sync, clk_sync, data_sync;
    logic                   latch_prev, clk_prev;
    logic                   latch_rise, clk_rise;
    logic                   latch_evt, clk_evt, data_q;
    logic [23:0]            shreg;
    logic [4:0]             bitcnt;

    assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;
    assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            data_sync  <= '0;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], pmod_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pmod_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], pmod_data};
            latch_prev <= latch_sync[SYNC_STAGES-1];
            clk_prev   <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Edges are registered once so the latch acts on a shreg that a following
    // clk edge cannot disturb; latch wins when both rise together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_evt <= 1'b0;
            clk_evt   <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            latch_evt <= latch_rise;
            clk_evt   <= clk_rise & ~latch_rise;
            data_q    <= data_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (latch_evt) begin
            bitcnt <= '0;
        end else if (clk_evt) begin
            shreg <= {shreg[22:0], data_q};
            if (bitcnt != BITCNT_OVF)
                bitcnt <= bitcnt + 5'd1;
        end
    end

    // An all-ones word is an unplugged controller (pull-ups on the data line).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad1_buttons <= '0;
            pad2_buttons <= '0;
            pad1_present <= 1'b0;
            pad2_present <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (latch_evt) begin
                if (bitcnt == FRAME_BITS) begin
                    frame_valid  <= 1'b1;
                    pad2_present <= ~&shreg[23:12];
                    pad2_buttons <= (&shreg[23:12]) ? 12'h000 : shreg[23:12];
                    pad1_present <= ~&shreg[11:0];
                    pad1_buttons <= (&shreg[11:0]) ? 12'h000 : shreg[11:0];
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Bench for gamepad_pmod_rx: a frame-level model predicts each latch outcome
// and its output cycle; a compare process checks every output on every cycle.
`timescale 1ns/1ps
module tb_gamepad_pmod_rx;
    localparam int S  = 2;
    localparam int PH = S + 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pmod_latch = 1'b0, pmod_clk = 1'b0, pmod_data = 1'b0;
    logic [11:0] pad1_buttons, pad2_buttons;
    logic        pad1_present, pad2_present, frame_valid, frame_err;

    gamepad_pmod_rx #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data),
        .pad1_buttons(pad1_buttons), .pad2_buttons(pad2_buttons),
        .pad1_present(pad1_present), .pad2_present(pad2_present),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          good;
        logic [11:0] p1, p2;
        logic        pr1, pr2;
    } ev_t;

    ev_t         evq[$];
    bit          bits[$];
    logic [11:0] m_p1 = 0, m_p2 = 0;
    logic        m_pr1 = 0, m_pr2 = 0;
    int          checks = 0, errors = 0;
    int          nvalid = 0, nerr = 0, last_valid_cyc = 0, last_latch_cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: sampled 1ns after each rising clock edge.
    initial forever begin
        bit  ev, er;
        ev_t e;
        @(posedge clk);
        #1;
        ev = 0;
        er = 0;
        if (!rst_n) begin
            evq.delete();
            m_p1 = 0; m_p2 = 0; m_pr1 = 0; m_pr2 = 0;
        end else if (evq.size() > 0 && evq[0].at == cyc) begin
            e = evq.pop_front();
            if (e.good) begin
                ev = 1;
                m_p1 = e.p1; m_p2 = e.p2; m_pr1 = e.pr1; m_pr2 = e.pr2;
            end else begin
                er = 1;
            end
        end
        if (frame_valid === 1'b1) begin nvalid++; last_valid_cyc = cyc; end
        if (frame_err === 1'b1) nerr++;
        chk("frame_valid", frame_valid, ev);
        chk("frame_err", frame_err, er);
        chk("pad1_buttons", pad1_buttons, m_p1);
        chk("pad2_buttons", pad2_buttons, m_p2);
        chk("pad1_present", pad1_present, m_pr1);
        chk("pad2_present", pad2_present, m_pr2);
    end

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts and ends at a negedge with pmod_clk low; data set for the whole low phase.
    task automatic send_bit(bit b);
        pmod_data = b;
        wait_neg(PH + $urandom_range(0, 2));
        pmod_clk = 1'b1;
        bits.push_back(b);
        wait_neg(PH + $urandom_range(0, 2));
        pmod_clk = 1'b0;
    endtask

    task automatic do_latch(bit with_clk);
        ev_t         e;
        logic [11:0] w1, w2;
        wait_neg(PH);
        w1 = 0;
        w2 = 0;
        e.good = (bits.size() == 24);
        if (e.good)
            for (int i = 0; i < 12; i++) begin
                w2[11-i] = bits[i];
                w1[11-i] = bits[12+i];
            end
        e.pr1 = (w1 != 12'hFFF);
        e.pr2 = (w2 != 12'hFFF);
        e.p1  = e.pr1 ? w1 : 12'h000;
        e.p2  = e.pr2 ? w2 : 12'h000;
        e.at  = cyc + S + 2;
        last_latch_cyc = cyc;
        evq.push_back(e);
        bits.delete();
        pmod_latch = 1'b1;
        if (with_clk) pmod_clk = 1'b1;
        wait_neg(PH + $urandom_range(0, 2));
        pmod_latch = 1'b0;
        pmod_clk   = 1'b0;
        wait_neg(PH);
    endtask

    task automatic send_frame(logic [11:0] p1, logic [11:0] p2, int nbits);
        logic [23:0] w;
        w = {p2, p1};
        for (int i = 0; i < nbits; i++)
            send_bit(i < 24 ? w[23-i] : 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #900000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        // Reset held while pins toggle: compare process expects all-zero outputs.
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            pmod_latch = 1'($urandom_range(0, 1));
            pmod_clk   = 1'($urandom_range(0, 1));
            pmod_data  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        pmod_latch = 0; pmod_clk = 0; pmod_data = 0;
        wait_neg(3);
        chk("reset_no_pulses", nvalid + nerr, 0);
        rst_n = 1'b1;
        wait_neg(3);

        // Good frame: pad2 absent, pad1 = B+R.
        send_frame(12'h801, 12'hFFF, 24);
        do_latch(0);
        wait_neg(4);
        chk("good_p1_lit", pad1_buttons, 12'h801);
        chk("good_pr1_lit", pad1_present, 1);
        chk("good_p2_lit", pad2_buttons, 12'h000);
        chk("good_pr2_lit", pad2_present, 0);
        chk("valid_latency_lit", last_valid_cyc - last_latch_cyc, 4);
        chk("valid_count_lit", nvalid, 1);

        // Short frame then good frame.
        n0 = nerr;
        send_frame(12'h123, 12'h456, 23);
        do_latch(0);
        wait_neg(4);
        chk("short_err_lit", nerr - n0, 1);
        chk("short_hold_lit", pad1_buttons, 12'h801);
        send_frame(12'h010, 12'h000, 24);
        do_latch(0);
        wait_neg(4);
        chk("after_short_p1_lit", pad1_buttons, 12'h010);
        chk("after_short_pr_lit", {pad1_present, pad2_present}, 2'b11);

        // Long frame: counter saturates, outputs hold.
        n0 = nerr;
        send_frame(12'hAAA, 12'h555, 30);
        wait_neg(PH);
        chk("bitcnt_sat_lit", dut.bitcnt, 25);
        do_latch(0);
        wait_neg(4);
        chk("long_err_lit", nerr - n0, 1);
        chk("long_hold_lit", pad1_buttons, 12'h010);

        // Simultaneous latch and clk rise after 24 bits: good, no extra shift.
        send_frame(12'h3C5, 12'h0F0, 24);
        pmod_data = 1'b1;
        do_latch(1);
        wait_neg(4);
        chk("simul_p1_lit", pad1_buttons, 12'h3C5);
        chk("simul_p2_lit", pad2_buttons, 12'h0F0);
        chk("simul_shreg_lit", dut.shreg, 24'h0F03C5);

        // Mid-frame reset: partial frame lost, first latch errors.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        bits.delete();
        for (int i = 0; i < 8; i++) begin
            pmod_clk = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        pmod_clk = 0; pmod_latch = 0;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(3);
        n0 = nerr;
        do_latch(0);
        wait_neg(4);
        chk("rst_first_err_lit", nerr - n0, 1);
        send_frame(12'h7E1, 12'h18F, 24);
        do_latch(0);
        wait_neg(4);
        chk("rst_second_p1_lit", pad1_buttons, 12'h7E1);
        chk("rst_second_p2_lit", pad2_buttons, 12'h18F);

        // Randomised frames against the model.
        for (int f = 0; f < 40; f++) begin
            int          r, len;
            logic [11:0] a, b;
            r   = $urandom_range(0, 7);
            len = (r < 5) ? 24 : (r == 5) ? 23 : (r == 6) ? $urandom_range(25, 30) : $urandom_range(0, 22);
            a   = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            send_frame(a, b, len);
            pmod_data = 1'($urandom_range(0, 1));
            do_latch($urandom_range(0, 7) == 0);
            wait_neg($urandom_range(0, 5));
        end

        wait_neg(S + 4);
        chk("events_drained", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
